// File: rtl/clk_div_bank_pkg.sv
// Shared types and default constants for the clk_div_bank divider bank.
// Used by clk_div_chan and clk_div_bank.
package clk_div_bank_pkg;

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_RUN_PEND
  } chan_state_e;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_DIV_W   = 24;
  localparam int DEF_RST_DIV = 0;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, pending divisor and STOP/RUN/RUN_PEND FSM.
// Square-wave output flop exists only when CLK_DIV_BANK_SQUARE_EN is defined.
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int RST_DIV = DEF_RST_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick,
  output logic             sq_out,
  output logic             busy
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             wrap;
  chan_state_e      state;

  always_comb begin
    if (div_q == '0)
      state = ST_STOP;
    else if (pend_q)
      state = ST_RUN_PEND;
    else
      state = ST_RUN;
  end

  // The last count of a period; sync suppresses the tick of the cycle it lands in.
  assign wrap = (state != ST_STOP) && (cnt_q == div_q - DIV_W'(1));
  assign tick = wrap && !sync && !rst;
  assign busy = pend_q;

  always_comb begin
    div_d      = div_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    if (sync) begin
      // Old pending commits first; a same-cycle request then sees the result.
      cnt_d = '0;
      if (pend_q) begin
        div_d  = pend_div_q;
        pend_d = 1'b0;
      end
      if (cfg_we) begin
        if (div_d == '0) begin
          div_d = cfg_div;
        end else begin
          pend_d     = 1'b1;
          pend_div_d = cfg_div;
        end
      end
    end else begin
      case (state)
        ST_STOP: begin
          cnt_d = '0;
          if (cfg_we) div_d = cfg_div;
        end
        default: begin
          if (wrap) begin
            cnt_d = '0;
            if (pend_q) begin
              div_d  = pend_div_q;
              pend_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
          if (cfg_we) begin
            pend_d     = 1'b1;
            pend_div_d = cfg_div;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= DIV_W'(RST_DIV);
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_div_q <= '0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
    end
  end

`ifdef CLK_DIV_BANK_SQUARE_EN
  logic sq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sq_q <= 1'b0;
    else if (sync)
      sq_q <= 1'b0;
    else if (tick)
      sq_q <= ~sq_q;
  end

  assign sq_out = sq_q;
`else
  assign sq_out = 1'b0;
`endif

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent programmable clock-enable dividers with shared sync.
// Define CLK_DIV_BANK_SQUARE_EN to enable the per-channel square-wave outputs.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int  NUM_CH  = DEF_NUM_CH,
  parameter int  DIV_W   = DEF_DIV_W,
  parameter int  RST_DIV = DEF_RST_DIV,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq_out,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] cfg_we;

  // Out-of-range channel numbers fall through to the default and are dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !busy[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    assign cfg_we[g] = cfg_valid && (cfg_ch == CH_W'(g)) && !busy[g];

    clk_div_chan #(
      .DIV_W  (DIV_W),
      .RST_DIV(RST_DIV)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .sync   (sync),
      .cfg_we (cfg_we[g]),
      .cfg_div(cfg_div),
      .tick   (tick[g]),
      .sq_out (sq_out[g]),
      .busy   (busy[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank: wide bank (RST_DIV=0) and a
// narrow 3-channel, 4-bit bank (RST_DIV=2). sq_out checks follow CLK_DIV_BANK_SQUARE_EN.
module tb_clk_div_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_sync, a_valid, a_ready;
  logic [1:0]  a_ch;
  logic [23:0] a_div;
  logic [3:0]  a_tick, a_sq, a_busy;

  logic        b_sync, b_valid, b_ready;
  logic [1:0]  b_ch;
  logic [3:0]  b_div;
  logic [2:0]  b_tick, b_sq, b_busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_tick, exp_sq;

  clk_div_bank #(.NUM_CH(4), .DIV_W(24), .RST_DIV(0)) dut_a (
    .clk(clk), .rst(rst), .sync(a_sync), .cfg_valid(a_valid), .cfg_ch(a_ch),
    .cfg_div(a_div), .cfg_ready(a_ready), .tick(a_tick), .sq_out(a_sq), .busy(a_busy)
  );

  clk_div_bank #(.NUM_CH(3), .DIV_W(4), .RST_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .sync(b_sync), .cfg_valid(b_valid), .cfg_ch(b_ch),
    .cfg_div(b_div), .cfg_ready(b_ready), .tick(b_tick), .sq_out(b_sq), .busy(b_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, drive both banks, let outputs settle.
  task automatic applyStimulus(input logic as, input logic av, input logic [1:0] ac, input logic [23:0] ad,
                               input logic bs, input logic bv, input logic [1:0] bc, input logic [3:0] bd);
    @(posedge clk);
    #1;
    a_sync = as; a_valid = av; a_ch = ac; a_div = ad;
    b_sync = bs; b_valid = bv; b_ch = bc; b_div = bd;
    #1;
  endtask

  task automatic stepA(input logic s, input logic v, input logic [1:0] ch, input logic [23:0] d);
    applyStimulus(s, v, ch, d, 1'b0, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic stepB(input logic s, input logic v, input logic [1:0] ch, input logic [3:0] d);
    applyStimulus(1'b0, 1'b0, 2'd0, 24'd0, s, v, ch, d);
  endtask

  initial begin
    a_sync = 0; a_valid = 0; a_ch = 0; a_div = 0;
    b_sync = 0; b_valid = 0; b_ch = 0; b_div = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst a_tick", a_tick, 4'h0);
    checkOutput("rst a_busy", a_busy, 4'h0);
    checkOutput("rst a_sq", a_sq, 4'h0);
    checkOutput("rst a_ready", a_ready, 1'b1);
    checkOutput("rst b_tick", b_tick, 3'h0);
    checkOutput("rst b_busy", b_busy, 3'h0);

    // Release: bank A (RST_DIV=0) stays silent, bank B ticks on every second cycle.
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int r = 0; r < 6; r++) begin
      if (r > 0) stepA(1'b0, 1'b0, 2'd0, 24'd0);
      checkOutput($sformatf("rel a_tick r%0d", r), a_tick, 4'h0);
      checkOutput($sformatf("rel b_tick r%0d", r), b_tick, (r % 2 == 1) ? 3'h7 : 3'h0);
    end

    // Channel 0 from STOP, divisor 4.
    stepA(1'b0, 1'b1, 2'd0, 24'd4);
    checkOutput("ch0 cfg ready", a_ready, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      stepA(1'b0, 1'b0, 2'd0, 24'd0);
      checkOutput($sformatf("ch0 tick k%0d", k), a_tick[0], (k % 4 == 0));
`ifdef CLK_DIV_BANK_SQUARE_EN
      checkOutput($sformatf("ch0 sq k%0d", k), a_sq[0], ((k - 1) / 4) % 2);
`else
      checkOutput($sformatf("ch0 sq k%0d", k), a_sq[0], 1'b0);
`endif
    end

    // Channel 1 at 10, retargeted to 3 at cnt=2; a second request while pending is refused.
    stepA(1'b0, 1'b1, 2'd1, 24'd10);
    stepA(1'b0, 1'b0, 2'd1, 24'd0);
    stepA(1'b0, 1'b0, 2'd1, 24'd0);
    stepA(1'b0, 1'b1, 2'd1, 24'd3);
    checkOutput("ch1 accept ready", a_ready, 1'b1);
    checkOutput("ch1 accept busy", a_busy[1], 1'b0);
    for (int j = 4; j <= 19; j++) begin
      stepA(1'b0, (j == 4), 2'd1, 24'd7);
      checkOutput($sformatf("ch1 tick j%0d", j), a_tick[1], (j == 10) || (j > 10 && (j - 10) % 3 == 0));
      checkOutput($sformatf("ch1 busy j%0d", j), a_busy[1], (j <= 10));
      checkOutput($sformatf("ch1 ready j%0d", j), a_ready, (j > 10));
    end

    // Channel 2 at 6, stopped with divisor 0: one final tick, sq_out held afterwards.
    stepA(1'b0, 1'b1, 2'd2, 24'd6);
    for (int j = 1; j <= 20; j++) begin
      stepA(1'b0, (j == 2), 2'd2, 24'd0);
      checkOutput($sformatf("ch2 tick j%0d", j), a_tick[2], (j == 6));
      checkOutput($sformatf("ch2 busy j%0d", j), a_busy[2], (j >= 3 && j <= 6));
      checkOutput($sformatf("ch2 ready j%0d", j), a_ready, !(j >= 3 && j <= 6));
`ifdef CLK_DIV_BANK_SQUARE_EN
      checkOutput($sformatf("ch2 sq j%0d", j), a_sq[2], (j >= 7));
`else
      checkOutput($sformatf("ch2 sq j%0d", j), a_sq[2], 1'b0);
`endif
    end

    // Sync: ch2=5, ch3=7 timed so ch3 would wrap in the sync cycle; ch0 pending 6,
    // and a new request on running ch2 in the sync cycle becomes pending.
    stepA(1'b0, 1'b1, 2'd2, 24'd5);
    stepA(1'b0, 1'b1, 2'd3, 24'd7);
    repeat (5) stepA(1'b0, 1'b0, 2'd0, 24'd0);
    stepA(1'b0, 1'b1, 2'd0, 24'd6);
    checkOutput("sync pre ready0", a_ready, 1'b1);
    checkOutput("sync pre tick3", a_tick[3], 1'b0);
    stepA(1'b1, 1'b1, 2'd2, 24'd2);
    checkOutput("sync cycle tick", a_tick, 4'h0);
    checkOutput("sync cycle busy", a_busy, 4'b0001);
    checkOutput("sync cycle ready2", a_ready, 1'b1);
    exp_sq = 4'h0;
    for (int j = 1; j <= 14; j++) begin
      stepA(1'b0, 1'b0, 2'd0, 24'd0);
      exp_tick = {(j % 7 == 0), (j == 5) || (j > 5 && (j - 5) % 2 == 0), (j % 3 == 0), (j % 6 == 0)};
      checkOutput($sformatf("sync tick j%0d", j), a_tick, exp_tick);
      checkOutput($sformatf("sync busy j%0d", j), a_busy, (j <= 5) ? 4'b0100 : 4'b0000);
`ifdef CLK_DIV_BANK_SQUARE_EN
      checkOutput($sformatf("sync sq j%0d", j), a_sq, exp_sq);
`else
      checkOutput($sformatf("sync sq j%0d", j), a_sq, 4'h0);
`endif
      exp_sq = exp_sq ^ exp_tick;
    end

    // Divisor 1 on ch1: once committed, tick is constantly high.
    stepA(1'b0, 1'b1, 2'd1, 24'd1);
    checkOutput("div1 ready", a_ready, 1'b1);
    repeat (4) stepA(1'b0, 1'b0, 2'd1, 24'd0);
    for (int j = 0; j < 5; j++) begin
      stepA(1'b0, 1'b0, 2'd1, 24'd0);
      checkOutput($sformatf("div1 tick j%0d", j), a_tick[1], 1'b1);
      checkOutput($sformatf("div1 busy j%0d", j), a_busy[1], 1'b0);
    end

    // Reset while ch0 of both banks holds a pending divisor.
    applyStimulus(1'b0, 1'b1, 2'd0, 24'd9, 1'b0, 1'b1, 2'd0, 4'd5);
    applyStimulus(1'b0, 1'b0, 2'd0, 24'd0, 1'b0, 1'b0, 2'd0, 4'd0);
    checkOutput("pre-rst a_busy0", a_busy[0], 1'b1);
    checkOutput("pre-rst b_busy0", b_busy[0], 1'b1);
    checkOutput("pre-rst a_ready", a_ready, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("mid-rst a_tick", a_tick, 4'h0);
    checkOutput("mid-rst a_busy", a_busy, 4'h0);
    checkOutput("mid-rst a_sq", a_sq, 4'h0);
    checkOutput("mid-rst a_ready", a_ready, 1'b1);
    checkOutput("mid-rst b_tick", b_tick, 3'h0);
    checkOutput("mid-rst b_busy", b_busy, 3'h0);
    checkOutput("mid-rst b_sq", b_sq, 3'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int r = 0; r < 6; r++) begin
      if (r > 0) stepB(1'b0, 1'b0, 2'd0, 4'd0);
      checkOutput($sformatf("rel2 a_tick r%0d", r), a_tick, 4'h0);
      checkOutput($sformatf("rel2 a_busy r%0d", r), a_busy, 4'h0);
      checkOutput($sformatf("rel2 b_tick r%0d", r), b_tick, (r % 2 == 1) ? 3'h7 : 3'h0);
      checkOutput($sformatf("rel2 b_busy r%0d", r), b_busy, 3'h0);
    end

    // Narrow bank: divisor 15 (all-ones) committed by sync; out-of-range channel ignored.
    stepB(1'b0, 1'b1, 2'd1, 4'd15);
    checkOutput("max ready", b_ready, 1'b1);
    checkOutput("max tick r6", b_tick, 3'h0);
    stepB(1'b1, 1'b1, 2'd3, 4'd1);
    checkOutput("oob ready", b_ready, 1'b1);
    checkOutput("oob sync tick", b_tick, 3'h0);
    checkOutput("oob sync busy", b_busy, 3'b010);
    for (int j = 1; j <= 46; j++) begin
      stepB(1'b0, 1'b0, 2'd0, 4'd0);
      checkOutput($sformatf("max tick j%0d", j), b_tick, {(j % 2 == 0), (j % 15 == 0), (j % 2 == 0)});
      if (j == 1) checkOutput("max busy", b_busy, 3'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
